// File: rtl/btn_debounce_core.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce_core
//  Purpose  : MMIO slot core for the push buttons. Each raw pin passes through
//             a two-flop synchronizer and a per-bit debounce FSM. A low-to-high
//             debounced change latches a sticky rise event (write-1-to-clear)
//             and bumps an 8-bit press counter.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1   system clock
//    reset_n  in   1   asynchronous active-low reset
//    cs       in   1   slot chip select
//    read     in   1   read strobe (rd_data does not depend on it)
//    write    in   1   write strobe, qualified by cs
//    addr     in   5   register address, only addr[2:0] decoded
//    wr_data  in  32   write data
//    rd_data  out 32   combinational read data
//    btn_raw  in   W   asynchronous button pins
//  Register map (addr[2:0])
//    0 R  debounced levels      1 R  sticky rise events
//    2 W  rise W1C              3 R  press count / W clears it
//    4 R  sticky fall events    5 W  fall W1C   (only with BTN_DB_FALL_EN)
//  Build option
//    BTN_DB_FALL_EN : adds the sticky fall register at addrs 4/5.
//  Parameters: W <= 31, TICK_CNT >= 2, DB_TICKS in 1..15.
// ============================================================================
module btn_debounce_core #(
  parameter int W        = 5,
  parameter int TICK_CNT = 100_000,
  parameter int DB_TICKS = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  input  logic [W-1:0] btn_raw
);

  localparam int            TW        = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CNT - 1);
  localparam logic [3:0]    SC_LAST   = 4'(DB_TICKS - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_e;

  // Two-flop synchronizer.
  logic [W-1:0] sync_q;
  logic [W-1:0] btn_s_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      btn_s_q <= '0;
    end else begin
      sync_q  <= btn_raw;
      btn_s_q <= sync_q;
    end
  end

  // Free-running sample tick generator.
  logic [TW-1:0] tick_cnt_q;
  logic [TW-1:0] tick_cnt_d;
  logic          w_tick;

  assign w_tick     = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = w_tick ? '0 : tick_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tick_cnt_q <= '0;
    else          tick_cnt_q <= tick_cnt_d;
  end

  // Per-bit debounce FSM.
  logic [W-1:0] w_db;
  logic [W-1:0] w_rise_set;
`ifdef BTN_DB_FALL_EN
  logic [W-1:0] w_fall_set;
`endif

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    db_state_e  state_q;
    db_state_e  state_d;
    logic [3:0] sc_q;
    logic [3:0] sc_d;
    logic       rise_hit;
`ifdef BTN_DB_FALL_EN
    logic       fall_hit;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ZERO;
        sc_q    <= '0;
      end else begin
        state_q <= state_d;
        sc_q    <= sc_d;
      end
    end

    // A level reversal in a WAIT state always wins over a pending tick.
    always_comb begin
      state_d  = state_q;
      sc_d     = sc_q;
      rise_hit = 1'b0;
`ifdef BTN_DB_FALL_EN
      fall_hit = 1'b0;
`endif
      case (state_q)
        ZERO: begin
          if (btn_s_q[gi]) begin
            state_d = WAIT1;
            sc_d    = '0;
          end
        end
        WAIT1: begin
          if (!btn_s_q[gi]) begin
            state_d = ZERO;
          end else if (w_tick) begin
            if (sc_q == SC_LAST) begin
              state_d  = ONE;
              rise_hit = 1'b1;
            end else begin
              sc_d = sc_q + 4'd1;
            end
          end
        end
        ONE: begin
          if (!btn_s_q[gi]) begin
            state_d = WAIT0;
            sc_d    = '0;
          end
        end
        WAIT0: begin
          if (btn_s_q[gi]) begin
            state_d = ONE;
          end else if (w_tick) begin
            if (sc_q == SC_LAST) begin
              state_d  = ZERO;
`ifdef BTN_DB_FALL_EN
              fall_hit = 1'b1;
`endif
            end else begin
              sc_d = sc_q + 4'd1;
            end
          end
        end
        default: state_d = ZERO;
      endcase
    end

    assign w_db[gi]       = (state_q == ONE) || (state_q == WAIT0);
    assign w_rise_set[gi] = rise_hit;
`ifdef BTN_DB_FALL_EN
    assign w_fall_set[gi] = fall_hit;
`endif
  end

  // Sticky event registers and press counter. A new event in the same cycle
  // as a W1C of that bit leaves the bit set.
  logic         w_wr_en;
  logic [W-1:0] rise_q;
  logic [W-1:0] rise_d;
  logic [7:0]   press_cnt_q;
  logic [7:0]   press_cnt_d;
  logic [7:0]   w_rise_pop;

  assign w_wr_en = cs & write;

  always_comb begin
    w_rise_pop = '0;
    for (int k = 0; k < W; k++) w_rise_pop = w_rise_pop + {7'd0, w_rise_set[k]};
  end

  // A counter clear drops the old count but still counts presses that land
  // in the same cycle.
  always_comb begin
    rise_d = rise_q;
    if (w_wr_en && (addr[2:0] == 3'd2)) rise_d = rise_q & ~wr_data[W-1:0];
    rise_d      = rise_d | w_rise_set;
    press_cnt_d = (w_wr_en && (addr[2:0] == 3'd3)) ? 8'd0 : press_cnt_q;
    press_cnt_d = press_cnt_d + w_rise_pop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q      <= '0;
      press_cnt_q <= '0;
    end else begin
      rise_q      <= rise_d;
      press_cnt_q <= press_cnt_d;
    end
  end

`ifdef BTN_DB_FALL_EN
  logic [W-1:0] fall_q;
  logic [W-1:0] fall_d;

  always_comb begin
    fall_d = fall_q;
    if (w_wr_en && (addr[2:0] == 3'd5)) fall_d = fall_q & ~wr_data[W-1:0];
    fall_d = fall_d | w_fall_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fall_q <= '0;
    else          fall_q <= fall_d;
  end
`endif

  // Read mux: every source is a flop cleared by reset, so rd_data is 0 in reset.
  always_comb begin
    rd_data = '0;
    case (addr[2:0])
      3'd0: rd_data[W-1:0] = w_db;
      3'd1: rd_data[W-1:0] = rise_q;
      3'd3: rd_data[7:0]   = press_cnt_q;
`ifdef BTN_DB_FALL_EN
      3'd4: rd_data[W-1:0] = fall_q;
`endif
      default: rd_data = '0;
    endcase
  end

  // Inputs that carry no information for this slot.
  logic w_unused;
  assign w_unused = ^{read, addr[4:3], wr_data[31:W]};

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_debounce_core
//  Purpose  : Self-checking bench for btn_debounce_core. A behavioural model
//             counts stable sample ticks per button; reads push the model's
//             (or a fixed) expected value into a queue that a monitor drains.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btn_debounce_core;

  localparam int W        = 5;
  localparam int TICK_CNT = 4;
  localparam int DB_TICKS = 3;

  logic         clk;
  logic         reset_n;
  logic         cs;
  logic         read;
  logic         write;
  logic [4:0]   addr;
  logic [31:0]  wr_data;
  logic [31:0]  rd_data;
  logic [W-1:0] btn_raw;

  btn_debounce_core #(
    .W        (W),
    .TICK_CNT (TICK_CNT),
    .DB_TICKS (DB_TICKS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .btn_raw (btn_raw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Level of each button changes once the synchronized input has disagreed
  // with it continuously for DB_TICKS sample ticks after the first differing cycle.
  logic [W-1:0] m_sync1, m_sync2, m_db, m_pend, m_rise, m_fall, m_rset, m_fset;
  int           m_n[W];
  int           m_cyc;
  logic [7:0]   m_cnt;
  bit           m_tick;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sync1 = '0; m_sync2 = '0; m_db = '0; m_pend = '0;
      m_rise = '0; m_fall = '0; m_cnt = 8'd0; m_cyc = 0;
      for (int i = 0; i < W; i++) m_n[i] = 0;
    end else begin
      m_tick = ((m_cyc % TICK_CNT) == TICK_CNT - 1);
      m_rset = '0;
      m_fset = '0;
      for (int i = 0; i < W; i++) begin
        if (m_sync2[i] != m_db[i]) begin
          if (!m_pend[i]) begin
            m_pend[i] = 1'b1;
            m_n[i]    = 0;
          end else if (m_tick) begin
            m_n[i]++;
            if (m_n[i] == DB_TICKS) begin
              m_db[i]   = m_sync2[i];
              m_pend[i] = 1'b0;
              if (m_sync2[i]) m_rset[i] = 1'b1;
              else            m_fset[i] = 1'b1;
            end
          end
        end else begin
          m_pend[i] = 1'b0;
        end
      end
      if (cs && write && addr[2:0] == 3'd2) m_rise = m_rise & ~wr_data[W-1:0];
      m_rise = m_rise | m_rset;
      if (cs && write && addr[2:0] == 3'd5) m_fall = m_fall & ~wr_data[W-1:0];
      m_fall = m_fall | m_fset;
      if (cs && write && addr[2:0] == 3'd3) m_cnt = 8'd0;
      m_cnt   = m_cnt + 8'($countones(m_rset));
      m_sync2 = m_sync1;
      m_sync1 = btn_raw;
      m_cyc++;
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = '0;
    case (a[2:0])
      3'd0: v[W-1:0] = m_db;
      3'd1: v[W-1:0] = m_rise;
      3'd3: v[7:0]   = m_cnt;
`ifdef BTN_DB_FALL_EN
      3'd4: v[W-1:0] = m_fall;
`endif
      default: v = '0;
    endcase
    return v;
  endfunction

  // True when the coming clock edge will latch a new rise on bit 2.
  function automatic bit rise2_next();
    return m_sync2[2] && !m_db[2] && m_pend[2] &&
           ((m_cyc % TICK_CNT) == TICK_CNT - 1) && (m_n[2] == DB_TICKS - 1);
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always @(negedge clk) begin
    #2;
    if (cs && read) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_underflow: read at addr %0d with no expectation queued", addr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          errors++;
          $display("FAIL rd_addr%0d: got %08h expected %08h at t=%0t", addr[2:0], rd_data, mon_exp, $time);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cs = 1'b0; read = 1'b0; write = 1'b0;
    end
  endtask

  task automatic rd_model(input logic [4:0] a);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
    exp_q.push_back(model_read(a));
  endtask

  task automatic rd_const(input logic [4:0] a, input logic [31:0] v);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
    exp_q.push_back(v);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; read = 1'b0; write = 1'b1; addr = a; wr_data = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  bit found;
  int b;

  initial begin
    reset_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0; btn_raw = 5'h1F;

    // Reset with all buttons held.
    repeat (2) @(negedge clk);
    rd_const(5'd0, 32'h0); rd_const(5'd1, 32'h0); rd_const(5'd3, 32'h0);
    @(negedge clk);
    reset_n = 1'b1; cs = 1'b0; read = 1'b0;
    repeat (2) begin
      rd_const(5'd0, 32'h0); rd_const(5'd1, 32'h0); rd_const(5'd3, 32'h0);
    end
    idle(20);
    rd_model(5'd0); rd_model(5'd1); rd_model(5'd3);
    btn_raw = '0;
    idle(20);
    wr(5'd2, 32'h1F); wr(5'd3, 32'h0);
    rd_const(5'd1, 32'h0); rd_const(5'd3, 32'h0);

    // Clean press on bit 2.
    btn_raw[2] = 1'b1;
    idle(18);
    rd_const(5'd0, 32'h04); rd_const(5'd1, 32'h04); rd_const(5'd3, 32'h01);
    btn_raw[2] = 1'b0;
    idle(20);
    wr(5'd2, 32'h04); wr(5'd3, 32'h0);
    rd_const(5'd1, 32'h0);

    // Bounce on bit 0, then a stable high.
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) btn_raw[0] = ~btn_raw[0];
      rd_const(5'd0, 32'h0);
    end
    rd_const(5'd1, 32'h0);
    btn_raw[0] = 1'b1;
    idle(20);
    rd_const(5'd0, 32'h01); rd_const(5'd1, 32'h01); rd_const(5'd3, 32'h01);
    btn_raw[0] = 1'b0;
    idle(20);
    wr(5'd2, 32'h1F); wr(5'd3, 32'h0);

    // W1C racing a new rise on bit 2.
    btn_raw[2] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (rise2_next()) begin
        found = 1'b1;
        cs = 1'b1; write = 1'b1; read = 1'b0; addr = 5'd2; wr_data = 32'h04;
      end else begin
        cs = 1'b0; write = 1'b0; read = 1'b0;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL race_setup: rise on bit 2 not predicted within 40 cycles (got none, required 1)");
    end
    rd_const(5'd1, 32'h04); rd_model(5'd1);
    wr(5'd2, 32'h04);
    rd_const(5'd1, 32'h0);
    btn_raw[2] = 1'b0;
    idle(20);

    // 256 presses on bit 1 wrap the counter.
    wr(5'd3, 32'h0);
    for (int k = 0; k < 256; k++) begin
      btn_raw[1] = 1'b1;
      idle($urandom_range(16, 22));
      btn_raw[1] = 1'b0;
      idle($urandom_range(16, 22));
    end
    rd_const(5'd3, 32'h0); rd_model(5'd3);
    wr(5'd2, 32'h1F);
    btn_raw = 5'b01001;
    idle(20);
    rd_const(5'd3, 32'h02); rd_const(5'd1, 32'h09);
    wr(5'd3, 32'h0);
    rd_const(5'd3, 32'h0);
    btn_raw = '0;
    idle(20);

    // Fall events on bit 4.
    wr(5'd2, 32'h1F); wr(5'd5, 32'h1F);
    btn_raw[4] = 1'b1;
    idle(20);
    btn_raw[4] = 1'b0;
    idle(20);
`ifdef BTN_DB_FALL_EN
    rd_const(5'd4, 32'h10);
    wr(5'd5, 32'h10);
    rd_const(5'd4, 32'h0);
`else
    rd_const(5'd4, 32'h0);
    rd_const(5'd5, 32'h0);
`endif

    // Reset in the middle of a debounce wait on bit 3.
    wr(5'd2, 32'h1F);
    btn_raw[3] = 1'b1;
    idle(8);
    @(negedge clk);
    reset_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
    rd_const(5'd1, 32'h0);
    @(negedge clk);
    reset_n = 1'b1; cs = 1'b0; read = 1'b0;
    rd_const(5'd0, 32'h0); rd_const(5'd1, 32'h0); rd_const(5'd3, 32'h0);
    idle(20);
    rd_const(5'd1, 32'h08); rd_model(5'd3);
    btn_raw = '0;
    idle(20);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 9))
        0, 1:    begin b = $urandom_range(0, W - 1); btn_raw[b] = ~btn_raw[b]; idle(1); end
        2:       begin
                   b = $urandom_range(0, W - 1);
                   btn_raw[b] = ~btn_raw[b];
                   idle($urandom_range(1, 3));
                   btn_raw[b] = ~btn_raw[b];
                 end
        3, 4, 5, 6: rd_model(5'($urandom));
        7:       wr(5'($urandom), $urandom);
        default: idle($urandom_range(1, 6));
      endcase
    end
    for (int a = 0; a < 8; a++) rd_model(5'(a));
    idle(5);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
